// File: rtl/wb_stage_buf.sv
// Writeback staging buffer: an in-order FIFO between MEM and the register file,
// with a head-entry bypass, retire trace outputs and a retired-instruction counter.
module wb_stage_buf #(
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 2,
   parameter int CNT_W = 64,
   localparam int OW   = $clog2(DEPTH) + 1,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AW-1:0]    in_rd,
   input  logic             in_rd_wen,
   input  logic [XLEN-1:0]  in_data,
   input  logic [XLEN-1:0]  in_pc,
   input  logic             rf_ready,
   output logic             rf_wen,
   output logic [AW-1:0]    rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             fwd_valid,
   output logic [AW-1:0]    fwd_rd,
   output logic [XLEN-1:0]  fwd_data,
   output logic [XLEN-1:0]  debug_wb_pc,
   output logic [3:0]       debug_wb_rf_wen,
   output logic [AW-1:0]    debug_wb_rf_wnum,
   output logic [XLEN-1:0]  debug_wb_rf_wdata,
   output logic [CNT_W-1:0] instret,
   output logic [OW-1:0]    occupancy
);

   localparam logic [OW-1:0] FULL = OW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [AW-1:0]   rd_q   [DEPTH];
   logic            wen_q  [DEPTH];
   logic [XLEN-1:0] data_q [DEPTH];
   logic [XLEN-1:0] pc_q   [DEPTH];

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          push, pop, not_empty, head_writes;

   logic [AW-1:0]   head_rd;
   logic            head_wen;
   logic [XLEN-1:0] head_data, head_pc;

   assign not_empty = (occupancy != '0);
   assign in_ready  = (occupancy < FULL);
   assign push      = in_valid && in_ready && !rst;
   // Reset dominates: nothing retires in the cycle reset is sampled.
   assign pop       = not_empty && rf_ready && !rst;

   assign head_rd   = rd_q[rd_ptr];
   assign head_wen  = wen_q[rd_ptr];
   assign head_data = data_q[rd_ptr];
   assign head_pc   = pc_q[rd_ptr];

   assign head_writes = head_wen && (head_rd != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[wr_ptr]   <= in_rd;
         wen_q[wr_ptr]  <= in_rd_wen;
         data_q[wr_ptr] <= in_data;
         pc_q[wr_ptr]   <= in_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         instret   <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            instret <= instret + CNT_W'(1);
         end
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   always_comb begin
      rf_wen   = pop && head_writes;
      rf_waddr = not_empty ? head_rd   : '0;
      rf_wdata = not_empty ? head_data : '0;

      fwd_valid = not_empty && head_writes && !rst;
      fwd_rd    = fwd_valid ? head_rd   : '0;
      fwd_data  = fwd_valid ? head_data : '0;

      debug_wb_pc       = pop ? head_pc   : '0;
      debug_wb_rf_wen   = {4{rf_wen}};
      debug_wb_rf_wnum  = pop ? head_rd   : '0;
      debug_wb_rf_wdata = pop ? head_data : '0;
   end

endmodule

// File: doc/wb_stage_buf.md
WB_STAGE_BUF -- requirements
Module: wb_stage_buf

Interface
REQ-001 Parameter XLEN, default 32, meaning data and PC width.
REQ-002 Parameter AW, default 5, meaning register-number width.
REQ-003 Parameter DEPTH, default 2, meaning writeback buffer entries; power of two, at least 1.
REQ-004 Parameter CNT_W, default 64, meaning retire-counter width.
REQ-005 One clock; reset is synchronous and active-high. Ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-006 in_valid input 1: MEM stage presents a result.
REQ-007 in_ready output 1: buffer accepts this cycle.
REQ-008 in_rd input AW: destination register.
REQ-009 in_rd_wen input 1: result writes the register file.
REQ-010 in_data input XLEN: writeback data.
REQ-011 in_pc input XLEN: instruction PC.
REQ-012 rf_ready input 1: register-file write port available.
REQ-013 rf_wen output 1: register-file write strobe.
REQ-014 rf_waddr output AW: register-file write address.
REQ-015 rf_wdata output XLEN: register-file write data.
REQ-016 fwd_valid, fwd_rd, fwd_data: outputs 1/AW/XLEN, head-entry bypass to decode.
REQ-017 debug_wb_pc output XLEN; debug_wb_rf_wen output 4; debug_wb_rf_wnum output AW; debug_wb_rf_wdata output XLEN.
REQ-018 instret output CNT_W: retired-instruction count.
REQ-019 occupancy output clog2(DEPTH)+1: entries held.

Function
REQ-020 Push SHALL occur when in_valid && in_ready; entry {rd, rd_wen, data, pc} written at the tail.
REQ-021 in_ready SHALL be (occupancy < DEPTH), registered-state only, with no combinational path from rf_ready.
REQ-022 Pop (retire) SHALL occur when occupancy != 0 && rf_ready; the head entry is removed.
REQ-023 No same-cycle bypass from input to output; minimum latency in_valid to rf_wen is 1 cycle.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged and retain both ordering and data.
REQ-025 When full, in_ready is 0 even if a pop occurs that cycle; the freed slot is usable the next cycle.
REQ-026 Pointers SHALL wrap modulo DEPTH; entries retire strictly in push order.
REQ-027 rf_wen = pop && head.rd_wen && (head.rd != 0); writes to x0 still retire but never assert rf_wen.
REQ-028 rf_waddr and rf_wdata SHALL equal the head entry whenever occupancy != 0, and 0 otherwise.
REQ-029 fwd_valid = (occupancy != 0) && head.rd_wen && head.rd != 0; fwd_rd and fwd_data are the head entry fields, 0 when fwd_valid is 0.
REQ-030 debug_wb_pc = head.pc on a pop cycle, else 0; debug_wb_rf_wen = {4{rf_wen}}; debug_wb_rf_wnum and debug_wb_rf_wdata = head fields on a pop cycle, else 0.
REQ-031 instret SHALL increment by 1 on each pop cycle, including x0 and non-writing instructions; wraps from all-ones to 0.
REQ-032 occupancy SHALL be +1 on push only, -1 on pop only, and unchanged otherwise; never exceeds DEPTH.

Reset
REQ-033 While rst=1 at a clk edge, pointers, occupancy, and instret SHALL clear to 0; entry storage need not clear.
REQ-034 During and after reset, in_ready=1 (occupancy 0) and rf_wen, fwd_valid, and all debug outputs are 0.
REQ-035 Reset asserted mid-operation SHALL discard all buffered entries with no rf_wen in the reset cycle or after it.

Verification
REQ-036 Single push: push rd=3, data=0xDEADBEEF, pc=0x1000 with rf_ready=1 -> next cycle rf_wen=1, waddr=3, wdata=0xDEADBEEF, debug_wb_pc=0x1000, debug_wb_rf_wen=0xF, and instret 0->1.
REQ-037 x0 suppression: push rd=0, rd_wen=1 -> retire cycle has rf_wen=0, debug_wb_rf_wen=0, fwd_valid=0, and instret still increments.
REQ-038 Backpressure: rf_ready=0, push 3 entries with DEPTH=2 -> in_ready=0 after 2 entries and the third is held at the source; raise rf_ready -> retires in order pc 0x0, 0x4, 0x8 on consecutive cycles.
REQ-039 Full plus pop: full buffer, rf_ready=1, in_valid=1 -> no push that cycle, push on the next cycle, occupancy 2->1->1.
REQ-040 Wrap-around: with DEPTH=4, stream 10 entries continuously with rf_ready=1 -> data out matches data in and order, and instret=10.
REQ-041 Reset mid-stream: rst=1 with occupancy 2 -> following cycle occupancy=0, instret=0, rf_wen=0, in_ready=1.
